pic_vec: RTL

Interrupt vectoring stage directly downstream of the PIC status table. It reduces the unmasked pending status vector to a highest-priority source ID and presents a request/claim/complete handshake to the CPU core. On claim it issues a one-cycle clear strobe back into the PIC status register. Everything runs on the PIC's pclk domain.

---
 rtl/pic_vec_pkg.sv | 23 ++
 rtl/pic_vec_prio.sv | 20 ++
 rtl/pic_vec.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pic_vec_pkg.sv
// Shared definitions for the pic_vec interrupt vectoring stage: FSM states,
// the "no interrupt" ID and the ID-to-clear-vector helper.
package pic_vec_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      CLAIMED = 2'd2
   } state_t;

   localparam int         ID_NONE     = 0;
   localparam int         MAX_INT_NUM = 64;
   localparam logic [1:0] SETTLE_CNT  = 2'd2;

   // ID n clears source n-1; ID_NONE (or out of range) clears nothing.
   function automatic logic [MAX_INT_NUM-1:0] id_to_onehot(input int unsigned id);
      logic [MAX_INT_NUM-1:0] oh;
      oh = '0;
      if (id != ID_NONE && id <= MAX_INT_NUM) oh = MAX_INT_NUM'(1) << (id - 1);
      return oh;
   endfunction

endpackage

// File: rtl/pic_vec_prio.sv
// Combinational lowest-index-wins priority encoder: masked status vector to
// source ID (index + 1), ID_NONE when nothing is pending.
module pic_vec_prio
   import pic_vec_pkg::*;
#(
   parameter int PIC_INT_NUM = 16,
   parameter int ID_W        = 5
) (
   input  logic [PIC_INT_NUM-1:0] int_vec,
   output logic [ID_W-1:0]        id
);

   always_comb begin
      id = ID_W'(ID_NONE);
      for (int i = PIC_INT_NUM - 1; i >= 0; i--) begin
         if (int_vec[i]) id = ID_W'(i + 1);
      end
   end

endmodule

// File: rtl/pic_vec.sv
// Interrupt vectoring stage behind the PIC status table: request/claim/complete
// handshake with clear strobe. Define PIC_VEC_NEST_EN to enable preemption nesting.
module pic_vec
   import pic_vec_pkg::*;
#(
   parameter int PIC_INT_NUM = 16,
   parameter int ID_W        = 5,
   parameter int NEST_DEPTH  = 4
) (
   input  logic                   pclk,
   input  logic                   preset,
   input  logic [PIC_INT_NUM-1:0] int_sub00_sta,
   input  logic [PIC_INT_NUM-1:0] int_sub00_msk,
   input  logic                   irq_claim,
   input  logic                   irq_complete,
   output logic                   irq_req,
   output logic [ID_W-1:0]        irq_pend_id,
   output logic [ID_W-1:0]        irq_id,
   output logic                   irq_busy,
   output logic                   int_clr_en,
   output logic [PIC_INT_NUM-1:0] clr_ints
);

   localparam logic [ID_W-1:0] NO_ID = ID_W'(ID_NONE);

   if (NEST_DEPTH < 1 || PIC_INT_NUM > MAX_INT_NUM || (2 ** ID_W) <= PIC_INT_NUM) begin : g_bad_params
      $error("pic_vec: inconsistent PIC_INT_NUM / ID_W / NEST_DEPTH");
   end

   function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
      return (cnt >= SETTLE_CNT) ? SETTLE_CNT : cnt + 2'd1;
   endfunction

   state_t          state;
   logic [1:0]      settle_cnt;
   logic            cmpl_lat;
   logic [ID_W-1:0] prio_id;
   logic            settled;
   logic            preempt_ok;
   logic            do_claim;
   logic            do_complete;

   pic_vec_prio #(
      .PIC_INT_NUM (PIC_INT_NUM),
      .ID_W        (ID_W)
   ) u_prio (
      .int_vec (int_sub00_sta & ~int_sub00_msk),
      .id      (prio_id)
   );

   // Settled once our own clear has had time to drop out of irq_pend_id.
   assign settled = (state == CLAIMED) && (settle_cnt == SETTLE_CNT);

`ifdef PIC_VEC_NEST_EN
   localparam int SP_W  = $clog2(NEST_DEPTH + 1);
   localparam int IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

   logic [ID_W-1:0] stack [NEST_DEPTH];
   logic [SP_W-1:0] sp;
   logic [SP_W-1:0] sp_top;

   assign sp_top     = sp - SP_W'(1);
   assign preempt_ok = settled && (irq_pend_id != NO_ID) && (irq_pend_id < irq_id) &&
                       (sp != SP_W'(NEST_DEPTH));
`else
   assign preempt_ok = 1'b0;
`endif

   assign irq_req  = (state == REQ) || preempt_ok;
   assign irq_busy = (state == CLAIMED);

   // A claim beats a simultaneous complete.
   assign do_claim    = irq_claim && (((state == REQ) && (irq_pend_id != NO_ID)) || preempt_ok);
   assign do_complete = settled && (irq_complete || cmpl_lat) && !do_claim;

   always_ff @(posedge pclk) begin
      if (preset) begin
         state       <= IDLE;
         irq_pend_id <= NO_ID;
         irq_id      <= NO_ID;
         int_clr_en  <= 1'b0;
         clr_ints    <= '0;
         settle_cnt  <= '0;
         cmpl_lat    <= 1'b0;
`ifdef PIC_VEC_NEST_EN
         sp          <= '0;
`endif
      end else begin
         irq_pend_id <= prio_id;
         int_clr_en  <= do_claim;
         clr_ints    <= do_claim ? PIC_INT_NUM'(id_to_onehot(32'(irq_pend_id))) : '0;
         settle_cnt  <= do_claim ? 2'd0 : sat_inc(settle_cnt);

         if (do_complete) cmpl_lat <= 1'b0;
         else if ((state == CLAIMED) && !settled && irq_complete) cmpl_lat <= 1'b1;

         case (state)
            IDLE: begin
               if (irq_pend_id != NO_ID) state <= REQ;
            end
            REQ: begin
               if (irq_pend_id == NO_ID) begin
                  state <= IDLE;
               end else if (do_claim) begin
                  state  <= CLAIMED;
                  irq_id <= irq_pend_id;
               end
            end
            CLAIMED: begin
               if (do_claim) begin
`ifdef PIC_VEC_NEST_EN
                  stack[sp[IDX_W-1:0]] <= irq_id;
                  sp                   <= sp + SP_W'(1);
`endif
                  irq_id <= irq_pend_id;
               end else if (do_complete) begin
`ifdef PIC_VEC_NEST_EN
                  if (sp != '0) begin
                     irq_id <= stack[sp_top[IDX_W-1:0]];
                     sp     <= sp_top;
                  end else begin
                     irq_id <= NO_ID;
                     state  <= IDLE;
                  end
`else
                  irq_id <= NO_ID;
                  state  <= IDLE;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
